// File: rtl/fft_fifo_param.sv
// fft_fifo_param: parametrised show-ahead FIFO buffering FFT samples between the CCI-P read path and the FFT core.
// Ports: clk/reset (async, active-high); flush (sync clear of contents); enq_data/enq_en with not_full/almost_full;
// deq_data (head, valid while not_empty)/deq_en with not_empty/almost_empty; count/free occupancy;
// overflow/underflow sticky error flags cleared by clr_err.
module fft_fifo_param #(
  parameter int DATA_WIDTH    = 512,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  enq_en,
  output logic                  not_full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] deq_data,
  input  logic                  deq_en,
  output logic                  not_empty,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         free,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic enq_acc, deq_acc, ovf_set, udf_set;

  // Full/empty come from count alone, so pointers are free to wrap naturally.
  always_comb begin
    not_full     = count != CW'(DEPTH);
    not_empty    = count != '0;
    almost_full  = count >= CW'(AFULL_THRESH);
    almost_empty = count <= CW'(AEMPTY_THRESH);
    free         = CW'(DEPTH) - count;
    deq_data     = mem[rd_ptr];
    enq_acc      = enq_en & not_full & ~flush;
    deq_acc      = deq_en & not_empty & ~flush;
    ovf_set      = enq_en & ~not_full & ~flush;
    udf_set      = deq_en & ~not_empty & ~flush;
  end

  always_ff @(posedge clk)
    if (enq_acc) mem[wr_ptr] <= enq_data;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= flush ? '0 : wr_ptr + AW'(enq_acc);
      rd_ptr    <= flush ? '0 : rd_ptr + AW'(deq_acc);
      count     <= flush ? '0 : count + CW'(enq_acc) - CW'(deq_acc);
      // A new error in the same cycle as clr_err stays visible.
      overflow  <= (overflow & ~clr_err) | ovf_set;
      underflow <= (underflow & ~clr_err) | udf_set;
    end
endmodule

// File: tb/tb_fft_fifo_param.sv
// tb_fft_fifo_param: directed scoreboard bench for fft_fifo_param (DEPTH=8, 32-bit data).
module tb_fft_fifo_param;
  logic clk = 0, reset = 1, flush = 0, enq_en = 0, deq_en = 0, clr_err = 0;
  logic [31:0] enq_data = '0, deq_data;
  logic not_full, almost_full, not_empty, almost_empty, overflow, underflow;
  logic [3:0] count, free;
  int checks = 0, fails = 0;
  int mc = 0;
  bit movf = 0, mudf = 0;
  logic [31:0] q[$];

  fft_fifo_param #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .enq_data(enq_data), .enq_en(enq_en),
    .not_full(not_full), .almost_full(almost_full), .deq_data(deq_data), .deq_en(deq_en),
    .not_empty(not_empty), .almost_empty(almost_empty), .count(count), .free(free),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted pop is checked against the head of the expected queue.
  always @(negedge clk)
    if (!reset && !flush && deq_en && not_empty) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected got=%h expected no data", deq_data);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if (deq_data !== e) begin
          fails++;
          $display("FAIL deq_data got=%h expected=%h", deq_data, e);
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mc));
    chk({tag, ".free"}, 32'(free), 32'(8 - mc));
    chk({tag, ".not_full"}, 32'(not_full), 32'(mc != 8));
    chk({tag, ".not_empty"}, 32'(not_empty), 32'(mc != 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(mc >= 6));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(mc <= 1));
    chk({tag, ".overflow"}, 32'(overflow), 32'(movf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(mudf));
  endtask

  task automatic step(input string tag, input bit e, input logic [31:0] d, input bit r,
                      input bit f = 0, input bit c = 0);
    bit ea, da;
    enq_en = e; enq_data = d; deq_en = r; flush = f; clr_err = c;
    ea = e && mc != 8 && !f;
    da = r && mc != 0 && !f;
    if (f) q.delete();
    else if (ea) q.push_back(d);
    movf = (movf && !c) || (e && mc == 8 && !f);
    mudf = (mudf && !c) || (r && mc == 0 && !f);
    @(posedge clk);
    #1;
    mc = f ? 0 : mc + int'(ea) - int'(da);
    enq_en = 0; deq_en = 0; flush = 0; clr_err = 0;
    chk_all(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_all("reset");
    for (int i = 0; i < 8; i++) step("t1_enq", 1, 32'(i), 0);
    for (int i = 0; i < 8; i++) step("t1_deq", 0, 0, 1);
    for (int i = 0; i < 8; i++) step("t2_fill", 1, 32'h100 + 32'(i), 0);
    step("t2_full_enq_deq", 1, 32'hDEAD, 1);
    step("t2_clr", 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step("t2_drain", 0, 0, 1);
    step("t3_empty_enq_deq", 1, 32'hA5, 1);
    step("t3_pop", 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("t4_prime", 1, 32'h200 + 32'(i), 0);
    for (int i = 0; i < 100; i++) step("t4_steady", 1, 32'h300 + 32'(i), 1);
    for (int i = 0; i < 2; i++) step("t5_fill", 1, 32'h400 + 32'(i), 0);
    step("t5_flush", 1, 32'hBAD, 0, 1);
    step("t5_enq", 1, 32'h55, 0);
    step("t5_deq", 0, 0, 1);
    step("t6_udf", 0, 0, 1);
    for (int i = 0; i < 8; i++) step("t6_fill", 1, 32'h500 + 32'(i), 0);
    step("t6_ovf", 1, 32'hBEEF, 0);
    for (int i = 0; i < 4; i++) step("t6_deq", 0, 0, 1);
    #2 reset = 1;
    q.delete(); mc = 0; movf = 0; mudf = 0;
    #1 chk_all("t6_async_reset");
    @(posedge clk);
    #1 reset = 0;
    step("t6_enq", 1, 32'h77, 0);
    step("t6_deq", 0, 0, 1);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
